// File: rtl/ddr_ctrl_rsp_pkg.sv
// ddr_ctrl_rsp_pkg: register offsets, AXI response codes and decode helpers for the ctrl responder.
// Shared by both build flavours (DDR_CTRL_RSP_SLVERR_EN only affects the regfile).
package ddr_ctrl_rsp_pkg;

    localparam logic [7:0] STATUS_OFS      = 8'h00;
    localparam logic [7:0] INTR_STATE_OFS  = 8'h04;
    localparam logic [7:0] INTR_ENABLE_OFS = 8'h08;
    localparam logic [7:0] SCRATCH_OFS     = 8'h0C;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [5:0] reg_idx_t;

    function automatic reg_idx_t ofs2idx(input logic [7:0] ofs);
        return ofs[7:2];
    endfunction

endpackage

// File: rtl/ddr_ctrl_rsp_regfile.sv
// ddr_ctrl_rsp_regfile: decode, status/interrupt/scratch storage and registered interrupt.
// DDR_CTRL_RSP_SLVERR_EN selects SLVERR instead of OKAY for out-of-range accesses.
module ddr_ctrl_rsp_regfile
    import ddr_ctrl_rsp_pkg::*;
#(
    parameter int          NumScratch    = 4,
    parameter logic [31:0] ScratchRstVal = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        i_wr_en,
    input  logic [31:2] i_wr_addr,
    input  logic [31:0] i_wr_data,
    input  logic [31:2] i_rd_addr,
    input  logic        i_calib,
    output logic [31:0] o_rd_data,
    output logic [1:0]  o_rd_resp,
    output logic [1:0]  o_wr_resp,
    output logic        o_intr
);

`ifdef DDR_CTRL_RSP_SLVERR_EN
    localparam logic [1:0] ErrResp = RESP_SLVERR;
`else
    localparam logic [1:0] ErrResp = RESP_OKAY;
`endif

    localparam reg_idx_t ScrIdx  = ofs2idx(SCRATCH_OFS);
    localparam reg_idx_t LastIdx = reg_idx_t'(int'(ScrIdx) + NumScratch - 1);

    function automatic logic hit(input logic [31:2] a);
        return (a[31:8] == 24'h0) && (a[7:2] <= LastIdx);
    endfunction

    logic [31:0] r_scratch [NumScratch];
    logic        r_calib_q;
    logic        r_intr_state;
    logic        r_intr_enable;
    logic        r_intr;

    reg_idx_t    w_wr_idx;
    reg_idx_t    w_rd_idx;
    logic        w_wr_ok;
    logic        w_rd_ok;
    logic        w_we;
    logic        w_clr;
    logic        w_rise;
    logic [31:0] w_rd_data;

    assign w_wr_idx = i_wr_addr[7:2];
    assign w_rd_idx = i_rd_addr[7:2];
    assign w_wr_ok  = hit(i_wr_addr);
    assign w_rd_ok  = hit(i_rd_addr);
    assign w_we     = i_wr_en & w_wr_ok;
    assign w_clr    = w_we & (w_wr_idx == ofs2idx(INTR_STATE_OFS)) & i_wr_data[0];
    assign w_rise   = i_calib & ~r_calib_q;

    // Set takes priority over a same-cycle W1C clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_calib_q     <= 1'b0;
            r_intr_state  <= 1'b0;
            r_intr_enable <= 1'b0;
            r_intr        <= 1'b0;
            for (int k = 0; k < NumScratch; k++) r_scratch[k] <= ScratchRstVal;
        end else begin
            r_calib_q    <= i_calib;
            r_intr_state <= w_rise | (r_intr_state & ~w_clr);
            r_intr       <= r_intr_state & r_intr_enable;
            if (w_we && w_wr_idx == ofs2idx(INTR_ENABLE_OFS)) r_intr_enable <= i_wr_data[0];
            for (int k = 0; k < NumScratch; k++)
                if (w_we && w_wr_idx == reg_idx_t'(int'(ScrIdx) + k)) r_scratch[k] <= i_wr_data;
        end
    end

    always_comb begin
        w_rd_data = 32'h0;
        if (w_rd_idx == ofs2idx(STATUS_OFS))      w_rd_data = {31'h0, i_calib};
        if (w_rd_idx == ofs2idx(INTR_STATE_OFS))  w_rd_data = {31'h0, r_intr_state};
        if (w_rd_idx == ofs2idx(INTR_ENABLE_OFS)) w_rd_data = {31'h0, r_intr_enable};
        for (int k = 0; k < NumScratch; k++)
            if (w_rd_idx == reg_idx_t'(int'(ScrIdx) + k)) w_rd_data = r_scratch[k];
        if (!w_rd_ok) w_rd_data = 32'h0;
    end

    assign o_rd_data = w_rd_data;
    assign o_rd_resp = w_rd_ok ? RESP_OKAY : ErrResp;
    assign o_wr_resp = w_wr_ok ? RESP_OKAY : ErrResp;
    assign o_intr    = r_intr;

endmodule

// File: rtl/ddr_ctrl_axil_responder.sv
// ddr_ctrl_axil_responder: AXI4-Lite ctrl-port responder with status, interrupt and scratch registers.
// Define DDR_CTRL_RSP_SLVERR_EN to return SLVERR on out-of-range accesses.
module ddr_ctrl_axil_responder
    import ddr_ctrl_rsp_pkg::*;
#(
    parameter int          NumScratch    = 4,
    parameter logic [31:0] ScratchRstVal = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        axi_aw_valid_i,
    output logic        axi_aw_ready_o,
    input  logic [31:0] axi_aw_addr_i,
    input  logic        axi_w_valid_i,
    output logic        axi_w_ready_o,
    input  logic [31:0] axi_w_data_i,
    output logic        axi_b_valid_o,
    input  logic        axi_b_ready_i,
    output logic [1:0]  axi_b_resp_o,
    input  logic        axi_ar_valid_i,
    output logic        axi_ar_ready_o,
    input  logic [31:0] axi_ar_addr_i,
    output logic        axi_r_valid_o,
    input  logic        axi_r_ready_i,
    output logic [31:0] axi_r_data_o,
    output logic [1:0]  axi_r_resp_o,
    input  logic        calib_complete_i,
    output logic        interrupt_o
);

    logic        r_aw_held;
    logic [31:2] r_aw_addr;
    logic        r_w_held;
    logic [31:0] r_w_data;
    logic        r_b_valid;
    logic [1:0]  r_b_resp;
    logic        r_r_valid;
    logic [31:0] r_r_data;
    logic [1:0]  r_r_resp;

    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_ar_hs;
    logic        w_commit;
    logic [31:2] w_wr_addr;
    logic [31:0] w_wr_data;
    logic [31:0] w_rd_data;
    logic [1:0]  w_rd_resp;
    logic [1:0]  w_wr_resp;
    logic        w_unused;

    assign axi_aw_ready_o = !r_aw_held && !r_b_valid;
    assign axi_w_ready_o  = !r_w_held && !r_b_valid;
    assign axi_ar_ready_o = !r_r_valid;

    assign w_aw_hs   = axi_aw_valid_i && axi_aw_ready_o;
    assign w_w_hs    = axi_w_valid_i && axi_w_ready_o;
    assign w_ar_hs   = axi_ar_valid_i && axi_ar_ready_o;
    // Commit as soon as both halves are available, held or landing this cycle.
    assign w_commit  = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
    assign w_wr_addr = r_aw_held ? r_aw_addr : axi_aw_addr_i[31:2];
    assign w_wr_data = r_w_held ? r_w_data : axi_w_data_i;
    assign w_unused  = ^{axi_aw_addr_i[1:0], axi_ar_addr_i[1:0]};

    ddr_ctrl_rsp_regfile #(
        .NumScratch    (NumScratch),
        .ScratchRstVal (ScratchRstVal)
    ) u_regfile (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .i_wr_en   (w_commit),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_wr_data),
        .i_rd_addr (axi_ar_addr_i[31:2]),
        .i_calib   (calib_complete_i),
        .o_rd_data (w_rd_data),
        .o_rd_resp (w_rd_resp),
        .o_wr_resp (w_wr_resp),
        .o_intr    (interrupt_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_aw_held <= 1'b0;
            r_aw_addr <= '0;
            r_w_held  <= 1'b0;
            r_w_data  <= '0;
            r_b_valid <= 1'b0;
            r_b_resp  <= RESP_OKAY;
        end else begin
            if (w_aw_hs) r_aw_addr <= axi_aw_addr_i[31:2];
            if (w_w_hs) r_w_data <= axi_w_data_i;
            if (r_b_valid && axi_b_ready_i) r_b_valid <= 1'b0;
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_b_valid <= 1'b1;
                r_b_resp  <= w_wr_resp;
            end else begin
                if (w_aw_hs) r_aw_held <= 1'b1;
                if (w_w_hs) r_w_held <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_r_valid <= 1'b0;
            r_r_data  <= 32'h0;
            r_r_resp  <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_r_valid <= 1'b1;
            r_r_data  <= w_rd_data;
            r_r_resp  <= w_rd_resp;
        end else if (axi_r_ready_i) begin
            r_r_valid <= 1'b0;
        end
    end

    assign axi_b_valid_o = r_b_valid;
    assign axi_b_resp_o  = r_b_resp;
    assign axi_r_valid_o = r_r_valid;
    assign axi_r_data_o  = r_r_data;
    assign axi_r_resp_o  = r_r_resp;

endmodule
